// File: rtl/dmem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one data memory port between
// the processor path (port 0) and a DMA/debug master (port 1).
module dmem_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned BCW = $clog2(MAX_BURST + 1);
  localparam logic [BCW-1:0] BMAX = BCW'(MAX_BURST);

  logic           last_q, last_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic           rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Grant: a burst in progress (1..MAX_BURST-1) keeps the last port,
  // otherwise a tie alternates away from the last granted port.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (req0 && req1) begin
        if ((bcnt_q != '0) && (bcnt_q < BMAX)) begin
          gnt0 = ~last_q;
          gnt1 = last_q;
        end else begin
          gnt0 = last_q;
          gnt1 = ~last_q;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    mem_addr  = gnt1 ? addr1 : addr0;
    mem_wdata = gnt1 ? wdata1 : wdata0;
    mem_we    = (gnt0 & we0) | (gnt1 & we1);
  end

  // Next state: burst bookkeeping and per-port read capture.
  always_comb begin
    last_d    = last_q;
    bcnt_d    = '0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (gnt0 || gnt1) begin
      last_d = gnt1;
      if (last_q == gnt1) begin
        bcnt_d = (bcnt_q < BMAX) ? bcnt_q + BCW'(1) : BMAX;
      end else begin
        bcnt_d = BCW'(1);
      end
      if (gnt0 && !we0) begin
        rvalid0_d = 1'b1;
        rdata0_d  = mem_rdata;
      end
      if (gnt1 && !we1) begin
        rvalid1_d = 1'b1;
        rdata1_d  = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q    <= 1'b1;
      bcnt_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      last_q    <= last_d;
      bcnt_q    <= bcnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small combinational-read /
// synchronous-write memory model behind the shared port.
module tb_dmem_arbiter;

  logic        clk, reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  int errors = 0;
  int checks = 0;
  int unsigned exp_g [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = '0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20; wdata1 = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_rvalid0", 32'(rvalid0), 0);
    chk("rst_rdata0", rdata0, 0);
    step();
    reset = 1'b1;
    #1;
    chk("t1_gnt0", 32'(gnt0), 1);
    chk("t1_gnt1", 32'(gnt1), 0);
    chk("t1_addr", mem_addr, 32'h10);

    // both ports reading continuously: 4-grant bursts alternate
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t3_gnt0_%0d", k), 32'(gnt0), 32'(exp_g[k] == 0));
      chk($sformatf("t3_gnt1_%0d", k), 32'(gnt1), 32'(exp_g[k] == 1));
      step();
      chk($sformatf("t3_rv0_%0d", k), 32'(rvalid0), 32'(exp_g[k] == 0));
      chk($sformatf("t3_rv1_%0d", k), 32'(rvalid1), 32'(exp_g[k] == 1));
      if (exp_g[k] == 0) chk($sformatf("t3_rd0_%0d", k), rdata0, 32'h1000_0004);
      else               chk($sformatf("t3_rd1_%0d", k), rdata1, 32'h1000_0008);
      #1;
    end

    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("idle_gnt0", 32'(gnt0), 0);
    chk("idle_gnt1", 32'(gnt1), 0);
    chk("idle_we", 32'(mem_we), 0);
    step();
    chk("idle_rv0", 32'(rvalid0), 0);
    chk("idle_rv1", 32'(rvalid1), 0);
    chk("idle_rd0_hold", rdata0, 32'h1000_0004);

    // port 0 write then read back
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'hDEAD_BEEF;
    #1;
    chk("t2_w_gnt0", 32'(gnt0), 1);
    chk("t2_w_we", 32'(mem_we), 1);
    chk("t2_w_addr", mem_addr, 32'h40);
    chk("t2_w_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    chk("t2_w_rv0", 32'(rvalid0), 0);
    we0 = 1'b0;
    #1;
    chk("t2_r_gnt0", 32'(gnt0), 1);
    chk("t2_r_we", 32'(mem_we), 0);
    step();
    chk("t2_r_rv0", 32'(rvalid0), 1);
    chk("t2_r_rd0", rdata0, 32'hDEAD_BEEF);
    chk("t2_r_rv1", 32'(rvalid1), 0);
    req0 = 1'b0;
    step();
    chk("t2_rv0_drop", 32'(rvalid0), 0);

    // port 1 write with port 0 idle, then port 0 reads it back
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h80; wdata1 = 32'h11;
    #1;
    chk("t4_gnt1", 32'(gnt1), 1);
    chk("t4_we", 32'(mem_we), 1);
    chk("t4_addr", mem_addr, 32'h80);
    step();
    req1 = 1'b0; req0 = 1'b1; addr0 = 32'h80;
    #1;
    chk("t4_gnt0", 32'(gnt0), 1);
    step();
    chk("t4_rv0", 32'(rvalid0), 1);
    chk("t4_rd0", rdata0, 32'h11);

    // port 1 write request starved by port 0 burst, then withdrawn
    addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h84; wdata1 = 32'h55;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("t5_gnt0_%0d", k), 32'(gnt0), 1);
      chk($sformatf("t5_gnt1_%0d", k), 32'(gnt1), 0);
      chk($sformatf("t5_we_%0d", k), 32'(mem_we), 0);
      step();
    end
    req1 = 1'b0;
    #1;
    chk("t5_gnt0_after", 32'(gnt0), 1);
    step();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0;
    #1;
    chk("t5_rd_gnt1", 32'(gnt1), 1);
    step();
    chk("t5_rd_rv1", 32'(rvalid1), 1);
    chk("t5_rd1_nowrite", rdata1, 32'h1000_0021);

    // reset asserted while port 1 is granted a write
    we1 = 1'b1; addr1 = 32'h88; wdata1 = 32'h0000_0BAD;
    #1;
    chk("t6_gnt1_pre", 32'(gnt1), 1);
    chk("t6_we_pre", 32'(mem_we), 1);
    reset = 1'b0;
    #1;
    chk("t6_gnt1_rst", 32'(gnt1), 0);
    chk("t6_we_rst", 32'(mem_we), 0);
    step();
    chk("t6_we_hold", 32'(mem_we), 0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h88; we1 = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_gnt0_tie", 32'(gnt0), 1);
    chk("t6_gnt1_tie", 32'(gnt1), 0);
    chk("t6_rv0", 32'(rvalid0), 0);
    chk("t6_rv1", 32'(rvalid1), 0);
    chk("t6_rd0", rdata0, 0);
    chk("t6_rd1", rdata1, 0);
    step();
    chk("t6_rd_rv0", 32'(rvalid0), 1);
    chk("t6_rd_rv1", 32'(rvalid1), 0);
    chk("t6_nowrite", rdata0, 32'h1000_0022);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
